// File: rtl/layer_argmax_pkg.sv
// Shared configuration for the classification (argmax) stage.
// Provides the default layer geometry, the argmax FSM state type and the
// strict-greater compare helper used by the scan datapath.
package layer_argmax_pkg;

  localparam int L3_NN         = 10;
  localparam int NN_DATA_WIDTH = 16;
  localparam int L3_CLASS_W    = $clog2(L3_NN);

  // Operand width of gt(); callers extend their lanes to this width
  // (sign- or zero-extension matching the compare mode) before calling.
  localparam int GT_W = 64;

  typedef enum logic [1:0] {
    ARG_IDLE = 2'd0,
    ARG_SCAN = 2'd1,
    ARG_DONE = 2'd2
  } argmax_state_t;

  // Strict-greater decision; equal values return 0 so ties keep the incumbent.
  function automatic logic gt(input logic [GT_W-1:0] a,
                              input logic [GT_W-1:0] b,
                              input logic            signed_cmp);
    logic res;
    if (signed_cmp) begin
      res = ($signed(a) > $signed(b));
    end else begin
      res = (a > b);
    end
    return res;
  endfunction

endpackage

// File: rtl/layer_argmax_if.sv
// Bundle between the final fully-connected layer and the argmax stage.
//   i_valid      per-lane valid (bit j qualifies lane j)
//   i_data_flat  lane j at bits [j*data_width +: data_width]
//   o_busy       stage is scanning or presenting a result
//   o_valid      one-cycle result strobe
//   o_class      index of the winning lane
//   o_max        value of the winning lane
//   o_drop       one-cycle pulse: lane valids arrived while busy
// master = upstream producer / consumer side, slave = argmax stage.
interface layer_argmax_if
  import layer_argmax_pkg::*;
#(
  parameter int nn         = L3_NN,
  parameter int data_width = NN_DATA_WIDTH,
  parameter int class_w    = $clog2(nn)
);

  logic [nn-1:0]            i_valid;
  logic [nn*data_width-1:0] i_data_flat;
  logic                     o_busy;
  logic                     o_valid;
  logic [class_w-1:0]       o_class;
  logic [data_width-1:0]    o_max;
  logic                     o_drop;

  modport master (
    output i_valid, i_data_flat,
    input  o_busy, o_valid, o_class, o_max, o_drop
  );

  modport slave (
    input  i_valid, i_data_flat,
    output o_busy, o_valid, o_class, o_max, o_drop
  );

endinterface

// File: rtl/layer_argmax.sv
// Argmax classification stage.
// Collects one activation per output neuron (lane valids may arrive on
// different cycles), then scans the stored lanes one compare per clock and
// reports the index/value of the largest with a one-cycle o_valid strobe.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  layer_argmax_if.slave (lane inputs, result and status outputs)
module layer_argmax
  import layer_argmax_pkg::*;
#(
  parameter int nn         = L3_NN,
  parameter int data_width = NN_DATA_WIDTH,
  parameter int signed_cmp = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  layer_argmax_if.slave        bus
);

  localparam int class_w = $clog2(nn);
  localparam logic [class_w-1:0] LAST_IDX = class_w'(nn - 1);

  argmax_state_t          state_r;
  argmax_state_t          state_nx_s;

  logic [data_width-1:0]  lane_r [nn];
  logic [data_width-1:0]  lane_in_s [nn];
  logic [nn-1:0]          sticky_r;
  logic [class_w-1:0]     cnt_r;
  logic [data_width-1:0]  best_val_r;
  logic [class_w-1:0]     best_idx_r;

  logic                   o_valid_r;
  logic [class_w-1:0]     o_class_r;
  logic [data_width-1:0]  o_max_r;
  logic                   o_drop_r;

  logic                   busy_s;
  logic                   all_set_s;
  logic                   last_s;
  logic                   better_s;
  logic [data_width-1:0]  lane0_s;
  logic [data_width-1:0]  cand_s;

  // Extend a lane to the compare width without changing its value in the
  // selected number system.
  function automatic logic [GT_W-1:0] widen(input logic [data_width-1:0] v);
    logic fill;
    if (signed_cmp != 0) begin
      fill = v[data_width-1];
    end else begin
      fill = 1'b0;
    end
    return {{(GT_W-data_width){fill}}, v};
  endfunction

  // Unpack the flat lane bus into an array.
  always_comb begin
    for (int j = 0; j < nn; j++) begin
      lane_in_s[j] = bus.i_data_flat[j*data_width +: data_width];
    end
  end

  // Status and scan-step decode.
  always_comb begin
    busy_s    = (state_r == ARG_SCAN) || (state_r == ARG_DONE);
    all_set_s = &(sticky_r | bus.i_valid);
    last_s    = (cnt_r == LAST_IDX);
    // Lane 0 may be arriving on the very edge that completes the set.
    if (bus.i_valid[0]) begin
      lane0_s = lane_in_s[0];
    end else begin
      lane0_s = lane_r[0];
    end
    cand_s   = lane_r[cnt_r];
    better_s = gt(widen(cand_s), widen(best_val_r), signed_cmp != 0);
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ARG_IDLE: begin
        if (all_set_s) begin
          state_nx_s = ARG_SCAN;
        end else begin
          state_nx_s = ARG_IDLE;
        end
      end
      ARG_SCAN: begin
        if (last_s) begin
          state_nx_s = ARG_DONE;
        end else begin
          state_nx_s = ARG_SCAN;
        end
      end
      ARG_DONE: state_nx_s = ARG_IDLE;
      default:  state_nx_s = ARG_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ARG_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Lane capture, sequential scan and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < nn; j++) begin
        lane_r[j] <= '0;
      end
      sticky_r   <= '0;
      cnt_r      <= '0;
      best_val_r <= '0;
      best_idx_r <= '0;
      o_valid_r  <= 1'b0;
      o_class_r  <= '0;
      o_max_r    <= '0;
      o_drop_r   <= 1'b0;
    end else begin
      o_valid_r <= 1'b0;
      o_drop_r  <= busy_s && (|bus.i_valid);
      case (state_r)
        ARG_IDLE: begin
          for (int j = 0; j < nn; j++) begin
            if (bus.i_valid[j]) begin
              lane_r[j] <= lane_in_s[j];
            end
          end
          sticky_r <= sticky_r | bus.i_valid;
          if (all_set_s) begin
            best_val_r <= lane0_s;
            best_idx_r <= '0;
            cnt_r      <= class_w'(1);
          end
        end
        ARG_SCAN: begin
          if (better_s) begin
            best_val_r <= cand_s;
            best_idx_r <= cnt_r;
          end
          cnt_r <= cnt_r + class_w'(1);
          // Final compare bypasses best_* so the result lands this edge.
          if (last_s) begin
            o_valid_r <= 1'b1;
            if (better_s) begin
              o_class_r <= cnt_r;
              o_max_r   <= cand_s;
            end else begin
              o_class_r <= best_idx_r;
              o_max_r   <= best_val_r;
            end
          end
        end
        ARG_DONE: begin
          sticky_r <= '0;
          cnt_r    <= '0;
        end
        default: begin
          sticky_r <= '0;
          cnt_r    <= '0;
        end
      endcase
    end
  end

  assign bus.o_busy  = busy_s;
  assign bus.o_valid = o_valid_r;
  assign bus.o_class = o_class_r;
  assign bus.o_max   = o_max_r;
  assign bus.o_drop  = o_drop_r;

endmodule
